boot_sequencer: RTL and testbench

- Controller that sequences the board flash at power-up. It issues the read-array command, then copies a fixed-size boot image word by word from flash into main RAM through a req/ack write port.
- Sits between the flash pins and the RAM arbiter.
- Holds the CPU off (busy) until the image is resident; done then releases the core.

---
 rtl/boot_sequencer_pkg.sv | 28 ++
 rtl/boot_sequencer_flash_wait_timer.sv | 34 +++
 rtl/boot_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_boot_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_sequencer_pkg.sv
// boot_sequencer_pkg: shared state encoding, flash command and idle levels.
// Imported by boot_sequencer and flash_wait_timer.
package boot_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD_WE,
      ST_CMD_HOLD,
      ST_RD_WAIT,
      ST_RAM_WR,
      ST_DONE
   } state_e;

   localparam logic [15:0] FLASH_CMD_READ_ARRAY = 16'h00FF;

   // Flash strobes are active-low; these are their released levels.
   localparam logic FLASH_CE_IDLE = 1'b1;
   localparam logic FLASH_OE_IDLE = 1'b1;
   localparam logic FLASH_WE_IDLE = 1'b1;

   localparam int TMR_W = 3;

   // A phase of n cycles loads n-1 so it ends on the cycle the timer reads zero.
   function automatic logic [TMR_W-1:0] cyc_load(input int n);
      return TMR_W'(n - 1);
   endfunction

endpackage

// File: rtl/boot_sequencer_flash_wait_timer.sv
// flash_wait_timer: loadable 3-bit down-counter with a zero flag.
// Ports: clk, rst (sync, active-high), load_i/load_val_i, zero_o.
module flash_wait_timer
   import boot_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [TMR_W-1:0] load_val_i,
   output logic             zero_o
);

   logic [TMR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/boot_sequencer.sv
// boot_sequencer: at power-up writes read-array to NOR flash, then copies
// BOOT_WORDS words from flash into RAM through a req/ack write port.
// Ports: clk, rst (sync, active-high), start; flash_* NOR pins (flash_data
// driven only during the command write); ram_addr/ram_data/ram_req/ram_ack;
// busy, done (sticky), err, word_cnt (words committed).
// Optional: define BOOT_CHECKSUM_EN to read one trailing word after the
// image and flag err when it differs from the 16-bit sum of the image.
module boot_sequencer
   import boot_sequencer_pkg::*;
#(
   parameter logic [21:0] FLASH_BASE = 22'h000000,
   parameter logic [15:0] RAM_BASE   = 16'h0000,
   parameter logic [15:0] BOOT_WORDS = 16'd512,
   parameter int          WE_CYCLES  = 4,
   parameter int          RD_CYCLES  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [22:0] flash_addr,
   inout  wire  [15:0] flash_data,
   output logic        flash_byte,
   output logic        flash_vpen,
   output logic        flash_rp,
   output logic        flash_ce,
   output logic        flash_oe,
   output logic        flash_we,
   output logic [15:0] ram_addr,
   output logic [15:0] ram_data,
   output logic        ram_req,
   input  logic        ram_ack,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] word_cnt
);

   if (BOOT_WORDS < 16'd1) begin : g_bad_words
      $error("boot_sequencer: BOOT_WORDS must be >= 1");
   end
   if (WE_CYCLES < 1 || WE_CYCLES > 8) begin : g_bad_we
      $error("boot_sequencer: WE_CYCLES must be 1..8");
   end
   if (RD_CYCLES < 1 || RD_CYCLES > 8) begin : g_bad_rd
      $error("boot_sequencer: RD_CYCLES must be 1..8");
   end

`ifdef BOOT_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   localparam logic [TMR_W-1:0] WE_LOAD = cyc_load(WE_CYCLES);
   localparam logic [TMR_W-1:0] RD_LOAD = cyc_load(RD_CYCLES);

   state_e state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] rdata_q, rdata_d;
   logic [21:0] rd_word;
   logic [TMR_W-1:0] tmr_val;
   logic tmr_load;
   logic tmr_zero;
   logic drive;
   logic chk_rd;

   flash_wait_timer u_tmr (
      .clk       (clk),
      .rst       (rst),
      .load_i    (tmr_load),
      .load_val_i(tmr_val),
      .zero_o    (tmr_zero)
   );

   assign rd_word = FLASH_BASE + {6'd0, cnt_q};

`ifdef BOOT_CHECKSUM_EN
   // Once all words are committed the next read is the checksum word.
   assign chk_rd = (cnt_q == BOOT_WORDS);
`else
   assign chk_rd = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      tmr_load   = 1'b0;
      tmr_val    = RD_LOAD;
      flash_ce   = FLASH_CE_IDLE;
      flash_oe   = FLASH_OE_IDLE;
      flash_we   = FLASH_WE_IDLE;
      drive      = 1'b0;
      flash_addr = '0;
      ram_req    = 1'b0;
      ram_addr   = '0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d  = ST_CMD_WE;
               cnt_d    = '0;
               tmr_load = 1'b1;
               tmr_val  = WE_LOAD;
            end
         end
         ST_CMD_WE: begin
            flash_ce   = 1'b0;
            flash_we   = 1'b0;
            drive      = 1'b1;
            flash_addr = {FLASH_BASE, 1'b0};
            if (tmr_zero) begin
               state_d = ST_CMD_HOLD;
            end
         end
         ST_CMD_HOLD: begin
            flash_ce   = 1'b0;
            drive      = 1'b1;
            flash_addr = {FLASH_BASE, 1'b0};
            state_d    = ST_RD_WAIT;
            tmr_load   = 1'b1;
         end
         ST_RD_WAIT: begin
            flash_ce   = 1'b0;
            flash_oe   = 1'b0;
            flash_addr = {rd_word, 1'b0};
            if (tmr_zero) begin
               if (chk_rd) begin
                  state_d = ST_DONE;
               end else begin
                  rdata_d = flash_data;
                  state_d = ST_RAM_WR;
               end
            end
         end
         ST_RAM_WR: begin
            ram_req  = 1'b1;
            ram_addr = RAM_BASE + cnt_q;
            if (ram_ack) begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_d == BOOT_WORDS && !CHK_EN) begin
                  state_d = ST_DONE;
               end else begin
                  state_d  = ST_RD_WAIT;
                  tmr_load = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef BOOT_CHECKSUM_EN
   logic [15:0] sum_q, sum_d;
   logic err_q, err_d;
   logic arm, wr_fire, chk_fire;

   assign arm      = (state_q == ST_IDLE || state_q == ST_DONE) && start;
   assign wr_fire  = (state_q == ST_RAM_WR) && ram_ack;
   assign chk_fire = (state_q == ST_RD_WAIT) && tmr_zero && chk_rd;

   always_comb begin
      sum_d = sum_q;
      err_d = err_q;
      if (arm) begin
         sum_d = '0;
         err_d = 1'b0;
      end else if (wr_fire) begin
         sum_d = sum_q + rdata_q;
      end else if (chk_fire) begin
         err_d = (flash_data != sum_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= '0;
         err_q <= 1'b0;
      end else begin
         sum_q <= sum_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // State-decoded drive enable: reset returns to IDLE and frees the bus.
   assign flash_data = drive ? FLASH_CMD_READ_ARRAY : {16{1'bz}};

   assign flash_byte = 1'b1;
   assign flash_vpen = 1'b1;
   assign flash_rp   = 1'b1;
   assign ram_data   = rdata_q;
   assign word_cnt   = cnt_q;
   assign busy       = !(state_q == ST_IDLE || state_q == ST_DONE);
   assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_boot_sequencer.sv
// tb_boot_sequencer: directed + random stimulus against a sequential-script
// model of the boot copy; outputs compared every cycle on the falling edge.
module tb_boot_sequencer;

   localparam logic [21:0] FB = 22'h3FFFFE;
   localparam logic [15:0] RB = 16'hFFFF;
   localparam int BW = 4;
   localparam int WE = 4;
   localparam int RD = 4;
`ifdef BOOT_CHECKSUM_EN
   localparam int CHK = 1;
`else
   localparam int CHK = 0;
`endif
   localparam int LAT = 1 + WE + 1 + BW * (RD + 1) + CHK * RD;

   logic clk = 1'b0;
   logic rst, start, ram_ack;
   logic [22:0] flash_addr;
   wire  [15:0] flash_data;
   logic flash_byte, flash_vpen, flash_rp, flash_ce, flash_oe, flash_we;
   logic [15:0] ram_addr, ram_data, word_cnt;
   logic ram_req, busy, done, err;

   always #5 clk = ~clk;

   boot_sequencer #(
      .FLASH_BASE(FB), .RAM_BASE(RB), .BOOT_WORDS(16'(BW)),
      .WE_CYCLES(WE), .RD_CYCLES(RD)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .flash_addr(flash_addr), .flash_data(flash_data),
      .flash_byte(flash_byte), .flash_vpen(flash_vpen), .flash_rp(flash_rp),
      .flash_ce(flash_ce), .flash_oe(flash_oe), .flash_we(flash_we),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_req(ram_req),
      .ram_ack(ram_ack), .busy(busy), .done(done), .err(err),
      .word_cnt(word_cnt)
   );

   int vec = 0;
   int bad = 0;
   bit chk_en = 1'b0;
   int ack_mode = 0;
   logic [15:0] img [0:7];

   logic e_ce, e_oe, e_we, e_drv, e_req, e_busy, e_done, e_err;
   logic [22:0] e_faddr;
   logic [15:0] e_raddr, e_rdata, e_cnt;
   int m_word = -1;
   bit m_rd = 1'b0;

   logic [31:0] wq[$];
   logic [21:0] rq[$];
   int we_lo = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   // Flash device: outputs the image word while ce/oe are low, otherwise
   // drives a marker pattern whenever the controller must not drive.
   logic [21:0] f_idx;
   logic [15:0] tb_val;
   always_comb begin
      f_idx  = flash_addr[22:1] - FB;
      tb_val = 16'hA5C3;
      if (!flash_oe && !flash_ce) begin
         tb_val = (f_idx <= 22'(BW)) ? img[f_idx[2:0]] : 16'hDEAD;
      end
   end
   assign flash_data = e_drv ? {16{1'bz}} : tb_val;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   task automatic m_idle_outs();
      e_ce = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_drv = 1'b0;
      e_faddr = '0; e_req = 1'b0; e_raddr = '0; e_busy = 1'b0;
   endtask

   task automatic m_reset();
      m_idle_outs();
      e_rdata = '0; e_done = 1'b0; e_err = 1'b0; e_cnt = '0;
      m_rd = 1'b0; m_word = -1;
   endtask

   task automatic m_copy(output bit ab);
      logic [15:0] sum;
      sum = '0;
      ab = 1'b0;
      m_idle_outs();
      e_busy = 1'b1; e_done = 1'b0; e_err = 1'b0; e_cnt = '0;
      e_ce = 1'b0; e_we = 1'b0; e_drv = 1'b1; e_faddr = {FB, 1'b0};
      repeat (WE) begin
         @(posedge clk);
         if (rst) begin ab = 1'b1; return; end
      end
      e_we = 1'b1;
      @(posedge clk);
      if (rst) begin ab = 1'b1; return; end
      for (int w = 0; w < BW + CHK; w++) begin
         e_drv = 1'b0; e_ce = 1'b0; e_oe = 1'b0;
         e_faddr = {FB + 22'(w), 1'b0};
         m_word = w; m_rd = 1'b1;
         repeat (RD) begin
            @(posedge clk);
            if (rst) begin ab = 1'b1; return; end
         end
         m_rd = 1'b0;
         e_ce = 1'b1; e_oe = 1'b1; e_faddr = '0;
         if (w == BW) begin
            e_err = (img[BW] != sum);
            break;
         end
         e_rdata = img[w];
         e_req = 1'b1; e_raddr = RB + 16'(w);
         forever begin
            @(posedge clk);
            if (rst) begin ab = 1'b1; return; end
            if (ram_ack) break;
         end
         e_req = 1'b0; e_raddr = '0;
         sum = sum + e_rdata;
         e_cnt = 16'(w + 1);
      end
      e_busy = 1'b0; e_done = 1'b1;
   endtask

   initial begin
      bit ab;
      m_reset();
      forever begin
         @(posedge clk);
         if (rst) m_reset();
         else if (start) begin
            m_copy(ab);
            if (ab) m_reset();
         end
      end
   end

   // ---------------- RAM acknowledge ----------------
   initial begin
      int age;
      age = 0;
      ram_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         age = ram_req ? age + 1 : 0;
         case (ack_mode)
            0: ram_ack = 1'b1;
            1: ram_ack = (age >= 4);
            default: ram_ack = ($urandom_range(0, 2) == 0);
         endcase
      end
   end

   // ---------------- per-cycle compare and logging ----------------
   initial begin
      logic oe_prev;
      oe_prev = 1'b1;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("flash_ce", flash_ce, e_ce);
            chk("flash_oe", flash_oe, e_oe);
            chk("flash_we", flash_we, e_we);
            chk("flash_addr", flash_addr, e_faddr);
            if (e_drv) chk("cmd_data", flash_data, 16'h00FF);
            else       chk("bus_free", flash_data, tb_val);
            chk("ram_req", ram_req, e_req);
            chk("ram_addr", ram_addr, e_raddr);
            chk("ram_data", ram_data, e_rdata);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("err", err, e_err);
            chk("word_cnt", word_cnt, e_cnt);
            chk("static_pins", {flash_byte, flash_vpen, flash_rp}, 3'b111);
            if (ram_req && ram_ack && !rst) wq.push_back({ram_addr, ram_data});
            if (!flash_we) we_lo++;
            if (!flash_oe && oe_prev) rq.push_back(flash_addr[22:1]);
            oe_prev = flash_oe;
         end
      end
   end

   task automatic clear_logs();
      wq.delete();
      rq.delete();
      we_lo = 0;
   endtask

   task automatic wait_done(input int lim, output int n);
      n = 0;
      while (!done && n < lim) begin
         cyc();
         n++;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic chk_writes(input string nm);
      logic [15:0] ea [0:3];
      logic [15:0] ed [0:3];
      ea = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
      ed = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      chk({nm, "_nwrites"}, wq.size(), BW);
      for (int i = 0; i < BW; i++) begin
         chk({nm, "_write"}, (i < wq.size()) ? wq[i] : 32'hDEADDEAD,
             {ea[i], ed[i]});
      end
   endtask

   initial begin
      int n;
      logic [21:0] er [0:4];
      er = '{22'h3FFFFE, 22'h3FFFFF, 22'h000000, 22'h000001, 22'h000002};
      img[0] = 16'h1111; img[1] = 16'h2222;
      img[2] = 16'h3333; img[3] = 16'h4444;
      img[4] = 16'hAAAA; img[5] = 16'h0; img[6] = 16'h0; img[7] = 16'h0;
      rst = 1'b1;
      start = 1'b0;
      cyc();
      chk_en = 1'b1;
      repeat (2) cyc();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cnt", word_cnt, 0);
      chk("rst_strobes", {flash_ce, flash_oe, flash_we}, 3'b111);
      chk("rst_req", ram_req, 0);
      rst = 1'b0;
      cyc();

      // basic copy, ack tied high
      clear_logs();
      pulse_start();
      wait_done(300, n);
      chk("t1_latency", n + 1, LAT);
      chk("t1_busy", busy, 0);
      chk_writes("t1");
      chk("t1_nreads", rq.size(), BW + CHK);
      for (int i = 0; i < BW + CHK; i++) begin
         chk("t1_rdaddr", (i < rq.size()) ? rq[i] : 22'h2BAD, er[i]);
      end
      chk("t1_we_cycles", we_lo, WE);
      chk("t1_err", err, 0);

      // ack backpressure, checksum word wrong
      img[4] = 16'hAAAB;
      ack_mode = 1;
      clear_logs();
      pulse_start();
      wait_done(400, n);
      chk("t2_done", done, 1);
      chk_writes("t2");
      chk("t2_err", err, 32'(CHK));

      // reset in the second read
      ack_mode = 0;
      img[4] = 16'hAAAA;
      pulse_start();
      n = 0;
      while (!(m_rd && m_word == 1) && n < 100) begin
         cyc();
         n++;
      end
      chk("t3_in_read", {flash_oe, word_cnt}, {1'b0, 16'd1});
      rst = 1'b1;
      cyc();
      chk("t3_strobes", {flash_ce, flash_oe, flash_we}, 3'b111);
      chk("t3_req", ram_req, 0);
      chk("t3_cnt", word_cnt, 0);
      chk("t3_busy", busy, 0);
      rst = 1'b0;
      cyc();
      clear_logs();
      pulse_start();
      wait_done(300, n);
      chk("t3_done", done, 1);
      chk_writes("t3");

      // start held high: one copy, then re-arm from DONE
      clear_logs();
      start = 1'b1;
      cyc();
      wait_done(300, n);
      chk("t4_done", done, 1);
      chk("t4_nwrites", wq.size(), BW);
      cyc();
      chk("t4_rearm", {done, busy, flash_we, word_cnt}, {3'b010, 16'd0});
      start = 1'b0;
      wait_done(300, n);
      chk("t4_second", {done, 16'(wq.size())}, {1'b1, 16'(2 * BW)});

      // random traffic
      for (int it = 0; it < 40; it++) begin
         ack_mode = $urandom_range(0, 2);
         for (int k = 0; k <= BW; k++) img[k] = 16'($urandom);
         if ($urandom_range(0, 1) == 1) img[BW] = img[0] + img[1] + img[2] + img[3];
         repeat ($urandom_range(30, 150)) begin
            start = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 149) == 0);
            cyc();
         end
      end
      start = 1'b0;
      rst = 1'b0;
      repeat (3) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
